// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS R-type execute unit.
// Funct codes and the multiply/divide sequencer state encoding.
package mips_alu_pkg;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_RUN,
        MDU_FIX
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine.
// Ports: clk, reset, i_start, i_div, i_signed, i_a, i_b -> o_busy, o_done, o_hi, o_lo.
module mdu_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    mdu_state_t r_state, w_state_n;

    logic [CW-1:0]  r_cnt;
    logic           r_div;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_dz;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hw;
    logic [WIDTH-1:0] r_lw;
    logic [WIDTH-1:0] r_m;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_df;
    logic             w_ok;
    logic [WIDTH-1:0] w_hn;
    logic [WIDTH-1:0] w_ln;

    assign w_mag_a = (i_signed && i_a[M]) ? -i_a : i_a;
    assign w_mag_b = (i_signed && i_b[M]) ? -i_b : i_b;

    // Multiply step: {hw,lw} accumulates the product as the multiplier shifts out.
    assign w_sum = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_m} : '0);

    // Divide step: bring the next dividend bit into the partial remainder.
    assign w_sh = {r_hw, r_lw[M]};
    assign w_df = w_sh - {1'b0, r_m};
    assign w_ok = !w_df[WIDTH];

    assign w_hn = r_div ? (w_ok ? w_df[M:0] : w_sh[M:0])
                        : w_sum[WIDTH:1];
    assign w_ln = r_div ? {r_lw[M-1:0], w_ok}
                        : {w_sum[0], r_lw[M:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            MDU_IDLE: if (i_start) w_state_n = MDU_RUN;
            MDU_RUN:  if (r_cnt == CW'(WIDTH - 2)) w_state_n = MDU_FIX;
            MDU_FIX:  w_state_n = MDU_IDLE;
            default:  w_state_n = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == MDU_IDLE && i_start) begin
            r_cnt   <= '0;
            r_div   <= i_div;
            r_neg_q <= i_signed && (i_a[M] ^ i_b[M]);
            r_neg_r <= i_signed && i_a[M];
            r_dz    <= i_div && (i_b == '0);
            r_a     <= i_a;
            r_hw    <= '0;
            r_lw    <= w_mag_a;
            r_m     <= w_mag_b;
        end else if (r_state == MDU_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_hw  <= w_hn;
            r_lw  <= w_ln;
        end
    end

    // The last step is taken in MDU_FIX and sign-corrected on the way out.
    always_comb begin
        o_hi = w_hn;
        o_lo = w_ln;
        if (r_div) begin
            if (r_dz) begin
                o_hi = r_a;
                o_lo = '1;
            end else begin
                o_hi = r_neg_r ? -w_hn : w_hn;
                o_lo = r_neg_q ? -w_ln : w_ln;
            end
        end else if (r_neg_q) begin
            {o_hi, o_lo} = -{w_hn, w_ln};
        end
    end

    assign o_busy = (r_state != MDU_IDLE);
    assign o_done = (r_state == MDU_FIX);

endmodule

// File: rtl/mips_alu_mdu.sv
// Registered MIPS R-type execute unit: single-cycle ALU plus iterative MDU with HI/LO.
// Ports: clk, reset, in_valid/in_ready, op1, op2, ins -> out_valid/out_ready, result, ovf, illegal, busy, hi, lo.
module mips_alu_mdu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [31:0]      ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             illegal,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    logic [5:0]       w_funct;
    logic             w_nop;
    logic [SHW-1:0]   w_sa;
    logic [SHW-1:0]   w_sv;
    logic             w_accept;
    logic             w_is_mdu;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_mdu_hi;
    logic [WIDTH-1:0] w_mdu_lo;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_ill;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    assign w_funct  = ins[5:0];
    assign w_nop    = (ins == '0);
    assign w_sa     = SHW'(ins[10:6]);
    assign w_sv     = op1[SHW-1:0];
    assign w_is_mdu = !w_nop && (w_funct[5:2] == 4'b0110);
    assign in_ready = !w_busy && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_sum = op1 + op2;
    assign w_dif = op1 - op2;
    assign w_add_ovf = (op1[M] == op2[M]) && (w_sum[M] != op1[M]);
    assign w_sub_ovf = (op1[M] != op2[M]) && (w_dif[M] != op1[M]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        if (!w_nop) begin
            unique case (w_funct)
                FN_ADD: begin
                    w_res = w_sum;
                    w_ovf = w_add_ovf;
                end
                FN_SUB: begin
                    w_res = w_dif;
                    w_ovf = w_sub_ovf;
                end
                FN_ADDU: w_res = w_sum;
                FN_SUBU: w_res = w_dif;
                FN_AND:  w_res = op1 & op2;
                FN_OR:   w_res = op1 | op2;
                FN_XOR:  w_res = op1 ^ op2;
                FN_NOR:  w_res = ~(op1 | op2);
                FN_SLT:  w_res = {{M{1'b0}}, $signed(op1) < $signed(op2)};
                FN_SLTU: w_res = {{M{1'b0}}, op1 < op2};
                FN_SLL:  w_res = op2 << w_sa;
                FN_SRL:  w_res = op2 >> w_sa;
                FN_SRA:  w_res = $signed(op2) >>> w_sa;
                FN_SLLV: w_res = op2 << w_sv;
                FN_SRLV: w_res = op2 >> w_sv;
                FN_SRAV: w_res = $signed(op2) >>> w_sv;
                FN_MFHI: w_res = r_hi;
                FN_MFLO: w_res = r_lo;
                FN_JR, FN_MTHI, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w_res = '0;
                default: w_ill = 1'b1;
            endcase
        end
    end

    // MDU ops produce no result beat; a held result still drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
        end else if (w_accept && !w_is_mdu) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_ill    <= w_ill;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_mdu_hi;
            r_lo <= w_mdu_lo;
        end else if (w_accept && !w_nop) begin
            if (w_funct == FN_MTHI) r_hi <= op1;
            if (w_funct == FN_MTLO) r_lo <= op1;
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_accept && w_is_mdu),
        .i_div    (w_funct[1]),
        .i_signed (!w_funct[0]),
        .i_a      (op1),
        .i_b      (op2),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_hi     (w_mdu_hi),
        .o_lo     (w_mdu_lo)
    );

    assign out_valid = r_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign illegal   = r_ill;
    assign busy      = w_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Self-checking bench for mips_alu_mdu against an arithmetic reference model.
// Directed plan vectors plus randomized ALU/MDU traffic, backpressure and reset abort.
module tb_mips_alu_mdu;
    import mips_alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        illegal;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    localparam logic [5:0] FNS [21] = '{
        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
        FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV,
        FN_SRLV, FN_SRAV, FN_JR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO
    };

    mips_alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .ins       (ins),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .illegal   (illegal),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [5:0] f, input logic [4:0] s);
        return {21'd0, s, f};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference ALU: plain arithmetic on integer values.
    function automatic void ref_alu(input logic [31:0] i, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] h,
                                    input logic [31:0] l, output logic [31:0] r,
                                    output logic o, output logic il);
        longint s;
        logic [4:0] sh;
        sh = i[10:6];
        r = 0; o = 0; il = 0;
        if (i != 0) begin
            case (i[5:0])
                FN_ADD, FN_ADDU: begin
                    s = longint'($signed(a)) + longint'($signed(b));
                    r = a + b;
                    o = (i[5:0] == FN_ADD) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                FN_SUB, FN_SUBU: begin
                    s = longint'($signed(a)) - longint'($signed(b));
                    r = a - b;
                    o = (i[5:0] == FN_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                FN_AND:  r = a & b;
                FN_OR:   r = a | b;
                FN_XOR:  r = a ^ b;
                FN_NOR:  r = ~(a | b);
                FN_SLT:  r = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
                FN_SLTU: r = (longint'(a) < longint'(b)) ? 1 : 0;
                FN_SLL:  r = a * 0 + (b << sh);
                FN_SRL:  r = b >> sh;
                FN_SRA:  r = 32'(longint'($signed(b)) >>> sh);
                FN_SLLV: r = b << a[4:0];
                FN_SRLV: r = b >> a[4:0];
                FN_SRAV: r = 32'(longint'($signed(b)) >>> a[4:0]);
                FN_MFHI: r = h;
                FN_MFLO: r = l;
                FN_JR, FN_MTHI, FN_MTLO: r = 0;
                default: il = 1;
            endcase
        end
    endfunction

    function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f == FN_MULT) return 64'(sa * sb);
        if (f == FN_MULTU) return {32'd0, a} * {32'd0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (f == FN_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        ins = i; op1 = a; op2 = b; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout ins=%h in_ready=%b required 1", i, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, ovf, illegal, busy, in_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_flags got v/o/i/b/r=%b%b%b%b%b required 00001",
                     out_valid, ovf, illegal, busy, in_ready);
        end
        vectors++;
        if (result !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs got res=%h hi=%h lo=%h required 0/0/0", result, hi, lo);
        end
        m_hi = 0;
        m_lo = 0;
    endtask

    task automatic test_alu_directed();
        logic [31:0] ti [8] = '{mk(FN_ADD, 0), mk(FN_ADDU, 0), mk(FN_SUB, 0), mk(FN_SLT, 0),
                                mk(FN_SLTU, 0), mk(FN_SRA, 4), mk(FN_SRLV, 0), mk(FN_NOR, 0)};
        logic [31:0] ta [8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h0, 32'h4, 32'h0};
        logic [31:0] tb [8] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h8000_0000,
                                32'h8000_0000, 32'h0};
        logic [31:0] tr [8] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,
                                32'h0, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF};
        logic        to [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            send(ti[k], ta[k], tb[k]);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || result !== tr[k] || ovf !== to[k] || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL alu_dir[%0d] got v=%b r=%h o=%b i=%b required v=1 r=%h o=%b i=0",
                         k, out_valid, result, ovf, illegal, tr[k], to[k]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] i, a, b, u, er;
        logic [5:0] f;
        logic eo, ei;
        for (int k = 0; k < 150; k++) begin
            u = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                f = 6'($urandom_range(0, 63));
                if (f[5:2] == 4'b0110) f = FN_AND;
            end else begin
                f = FNS[$urandom_range(0, 20)];
            end
            i = {u[31:11], 5'($urandom_range(0, 31)), f};
            a = rnd32();
            b = rnd32();
            ref_alu(i, a, b, m_hi, m_lo, er, eo, ei);
            if (i != 0 && f == FN_MTHI) m_hi = a;
            if (i != 0 && f == FN_MTLO) m_lo = a;
            send(i, a, b);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || result !== er || ovf !== eo || illegal !== ei) begin
                miscompares++;
                $display("FAIL alu_rand ins=%h a=%h b=%h got v=%b r=%h o=%b i=%b required v=1 r=%h o=%b i=%b",
                         i, a, b, out_valid, result, ovf, illegal, er, eo, ei);
            end
            vectors++;
            if (hi !== m_hi || lo !== m_lo) begin
                miscompares++;
                $display("FAIL alu_rand_hilo ins=%h got hi=%h lo=%h required hi=%h lo=%h",
                         i, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er [8];
        logic eo [8];
        logic ei [8];
        logic [31:0] i, a, b;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || result !== er[k-1] || ovf !== eo[k-1] ||
                    illegal !== ei[k-1]) begin
                    miscompares++;
                    $display("FAIL b2b[%0d] got v=%b r=%h o=%b i=%b required v=1 r=%h o=%b i=%b",
                             k - 1, out_valid, result, ovf, illegal, er[k-1], eo[k-1], ei[k-1]);
                end
            end
            if (k < 8) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready[%0d] got in_ready=%b required 1", k, in_ready);
                end
                i = mk(FNS[$urandom_range(0, 20)], 5'($urandom_range(0, 31)));
                a = rnd32();
                b = rnd32();
                ref_alu(i, a, b, m_hi, m_lo, er[k], eo[k], ei[k]);
                if (i[5:0] == FN_MTHI) m_hi = a;
                if (i[5:0] == FN_MTLO) m_lo = a;
                ins = i; op1 = a; op2 = b; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        send(mk(FN_AND, 0), 32'h0F0F_FFFF, 32'hFFFF_0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ins = mk(FN_OR, 0); op1 = 32'h1200_0000; op2 = 32'h0000_0034; in_valid = 1'b1;
            end
            #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== 32'h0F0F_0000 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b required v=1 r=0f0f0000 rdy=0",
                         k, out_valid, result, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'h1200_0034) begin
            miscompares++;
            $display("FAIL bp_next got v=%b r=%h required v=1 r=12000034", out_valid, result);
        end
    endtask

    task automatic test_illegal();
        send(mk(6'b111111, 0), 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL illegal got v=%b i=%b r=%h required v=1 i=1 r=0", out_valid, illegal, result);
        end
        send(32'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || illegal !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL nop got v=%b i=%b r=%h required v=1 i=0 r=0", out_valid, illegal, result);
        end
    endtask

    task automatic test_mdu();
        logic [5:0]  df [6] = '{FN_MULT, FN_DIV, FN_DIVU, FN_DIV, FN_MULTU, FN_DIV};
        logic [31:0] da [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [31:0] db [6] = '{32'h3, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [5:0] f;
        logic [31:0] a, b;
        logic [63:0] e;
        int n;
        for (int k = 0; k < 20; k++) begin
            if (k < 6) begin
                f = df[k]; a = da[k]; b = db[k];
            end else begin
                f = 6'($urandom_range(24, 27));
                a = rnd32();
                b = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd32();
            end
            e = ref_mdu(f, a, b);
            send(mk(f, 0), a, b);
            n = 0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL mdu_start[%0d] got v=%b busy=%b required v=0 busy=1", k, out_valid, busy);
            end
            while (busy === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            vectors++;
            if (n != 32) begin
                miscompares++;
                $display("FAIL mdu_cycles[%0d] got %0d busy cycles required 32", k, n);
            end
            vectors++;
            if (hi !== e[63:32] || lo !== e[31:0]) begin
                miscompares++;
                $display("FAIL mdu[%0d] f=%b a=%h b=%h got hi=%h lo=%h required hi=%h lo=%h",
                         k, f, a, b, hi, lo, e[63:32], e[31:0]);
            end
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    task automatic test_mdu_interlock();
        logic [63:0] e;
        int stall;
        e = ref_mdu(FN_MULT, 32'hFFFF_FFF9, 32'h3);
        send(mk(FN_MULT, 0), 32'hFFFF_FFF9, 32'h3);
        @(negedge clk);
        ins = mk(FN_MFHI, 0); op1 = 32'h0; op2 = 32'h0; in_valid = 1'b1;
        stall = 0;
        while (in_ready !== 1'b1 && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        vectors++;
        if (stall != 32) begin
            miscompares++;
            $display("FAIL mfhi_stall got %0d stalled cycles required 32", stall);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || result !== e[63:32]) begin
            miscompares++;
            $display("FAIL mfhi_value got v=%b r=%h required v=1 r=%h", out_valid, result, e[63:32]);
        end
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic test_reset_mid_div();
        send(mk(FN_DIV, 0), 32'hFFFF_FFF9, 32'h2);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || hi !== 32'h0 ||
            lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_div got busy=%b v=%b rdy=%b hi=%h lo=%h required 0/0/1/0/0",
                     busy, out_valid, in_ready, hi, lo);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_abort got busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        m_hi = 0;
        m_lo = 0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op1 = 0;
        op2 = 0;
        ins = 0;
        vectors = 0;
        miscompares = 0;
        m_hi = 0;
        m_lo = 0;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_mdu();
        test_mdu_interlock();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_alu_mdu.md
Name: mips_alu_mdu

Overview:
Parametrised, registered MIPS R-type execute unit: single-cycle ALU ops plus an iterative multiply/divide unit (MDU) with HI/LO registers. It sits in the EX stage of the pipeline and takes operands and the full instruction word. It returns registered results over a valid/ready handshake and stalls issue while the MDU iterates.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8
SHW, $clog2(WIDTH), shift-amount bits used (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  op1/op2/ins valid
in_ready  out  1  unit can accept this cycle
op1  in  WIDTH  rs operand
op2  in  WIDTH  rt operand
ins  in  32  full instruction; funct = ins[5:0], shamt = ins[10:6]
out_valid  out  1  result/flags valid
out_ready  in  1  consumer takes result
result  out  WIDTH  registered result
ovf  out  1  signed overflow (add/sub only), registered with result
illegal  out  1  unknown funct, registered with result
busy  out  1  MDU iterating
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Single clock. Reset is synchronous and active-high. Port names are clk and reset.
- Reset values: out_valid=0, result=0, ovf=0, illegal=0, busy=0, hi=0, lo=0. Reset mid-operation aborts the MDU, leaves HI/LO at 0 and drops any pending result.
- Handshake:
  - in_ready = !busy && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - The output register holds result, ovf and illegal stable while out_valid && !out_ready.
- Single-cycle ops write result on the accept edge. out_valid is high the next cycle, so latency is 1.
  - Back-to-back issue is allowed when out_ready=1.
- Functs:
  - add/addu/sub/subu: wrap modulo 2^WIDTH. ovf=1 only for add/sub signed overflow. The result is still written.
  - and/or/xor/nor: bitwise.
  - slt: 1 if signed op1 < op2, else 0. sltu: unsigned compare.
  - sll/srl/sra: shift op2 by shamt[SHW-1:0]. sra sign-fills from op2[WIDTH-1].
  - sllv/srlv/srav: shift op2 by op1[SHW-1:0].
  - mfhi/mflo: result = hi/lo.
  - mthi/mtlo: hi/lo = op1 on accept. out_valid pulses with result=0.
  - jr: result=0.
  - ins==0 (nop): result=0, illegal=0.
  - Any other funct: result=0, illegal=1.
- MDU ops (mult/multu/div/divu):
  - On accept, operands are latched; signed forms convert to magnitude and record signs.
  - busy goes high the next cycle for exactly WIDTH cycles: shift-add for multiply, restoring for divide.
  - HI/LO update on the final busy edge, sign-corrected. in_ready returns the following cycle.
  - No out_valid is generated for MDU ops.
- MDU results:
  - mult: {hi,lo} = full 2*WIDTH product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero: lo = all ones, hi = dividend. No trap.
  - Signed MIN / -1: lo = MIN, hi = 0.
- A pending output may drain (out_ready) while busy. mfhi issued after an MDU op is interlocked by in_ready until HI/LO are final.

Decomposition:
- Package mips_alu_pkg: funct localparams (FN_ADD=6'b100000, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU), plus the MDU state enum {MDU_IDLE, MDU_RUN, MDU_FIX}.
- Sub-module mdu_iter (WIDTH):
  - Inputs: start, op, signed flag, operands.
  - Outputs: busy, done, hi, lo.
  - Contains the iteration counter and sign fix-up.
- The top level holds the decode, the single-cycle datapath, the output register and the handshake.

Test Plan:
- add op1=0x7FFFFFFF, op2=1 -> result 0x80000000, ovf=1, out_valid one cycle after accept. addu with the same operands -> same result, ovf=0.
- slt op1=0xFFFFFFFF, op2=1 -> result 1. sltu with the same operands -> 0. sra op2=0x80000000, shamt=4 -> 0xF8000000.
- mult op1=0xFFFFFFF9 (-7), op2=3 -> busy for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. mfhi presented during busy is held off (in_ready=0) and returns 0xFFFFFFFF once accepted.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu x/0 with x=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
- Backpressure: out_ready=0 for 3 cycles after an and result 0x0F0F0000 -> result and out_valid held stable, in_ready=0. The next op is accepted on the cycle out_ready rises.
- reset asserted mid-div (cycle 10 of 32) -> next cycle busy=0, hi=lo=0, out_valid=0, in_ready=1. Funct 6'b111111 -> illegal=1, result=0.
